// File: rtl/conv_layer_sched.sv
// Layer-level scheduler for the conv engine: fetches per-layer descriptors from BRAM,
// launches the engine once per layer, and reports network done or error (timeout/abort).
module conv_layer_sched #(
    parameter int unsigned DESC_WORDS = 4,
    parameter int unsigned MAX_LAYERS = 64,
    parameter int unsigned TIMEOUT    = 2**20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        abort,
    input  logic [31:0] desc_base,
    input  logic [7:0]  layer_cnt,
    output logic        desc_en,
    output logic [31:0] desc_addr,
    input  logic [31:0] desc_rdata,
    output logic [31:0] cfg_in_base,
    output logic [31:0] cfg_out_base,
    output logic [31:0] cfg_w_base,
    output logic [31:0] cfg_ctrl,
    output logic        conv_start,
    input  logic        conv_finish,
    output logic [7:0]  cur_layer,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned KW = $clog2(DESC_WORDS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {StIdle, StFetch, StLaunch, StRun, StNext, StFin} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q;
    logic [31:0]   addr_ptr_q;
    logic [7:0]    cnt_q, cur_layer_q;
    logic [TW-1:0] tmo_q;
    logic          fin_prev_q, abort_pend_q, err_q, zero_done_q;
    logic [31:0]   in_base_q, out_base_q, w_base_q, ctrl_q;

    logic       fin_edge, abort_run, fetch_last, tmo_hit, more, err_set;
    logic [7:0] cnt_clamp;

    assign cnt_clamp  = (layer_cnt > 8'(MAX_LAYERS)) ? 8'(MAX_LAYERS) : layer_cnt;
    assign fin_edge   = conv_finish & ~fin_prev_q;
    // An abort seen at any point in RUN is held until the layer finishes.
    assign abort_run  = abort | abort_pend_q;
    assign fetch_last = (k_q == KW'(DESC_WORDS));
    assign tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
    assign more       = ({1'b0, cur_layer_q} + 9'd1) < {1'b0, cnt_q};

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            StIdle:   if (go && cnt_clamp != 8'd0) state_d = StFetch;
            StFetch: begin
                if (fetch_last) begin
                    state_d = abort ? StIdle : StLaunch;
                    err_set = abort;
                end
            end
            StLaunch: begin
                state_d = abort ? StIdle : StRun;
                err_set = abort;
            end
            StRun: begin
                if (fin_edge) begin
                    state_d = abort_run ? StIdle : StNext;
                    err_set = abort_run;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    err_set = 1'b1;
                end
            end
            StNext: begin
                state_d = abort ? StIdle : (more ? StFetch : StFin);
                err_set = abort;
            end
            StFin:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            k_q          <= '0;
            addr_ptr_q   <= '0;
            cnt_q        <= '0;
            cur_layer_q  <= '0;
            tmo_q        <= '0;
            fin_prev_q   <= 1'b0;
            abort_pend_q <= 1'b0;
            err_q        <= 1'b0;
            zero_done_q  <= 1'b0;
            in_base_q    <= '0;
            out_base_q   <= '0;
            w_base_q     <= '0;
            ctrl_q       <= '0;
        end else begin
            state_q     <= state_d;
            fin_prev_q  <= conv_finish;
            zero_done_q <= 1'b0;
            if (err_set) err_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (go) begin
                        cnt_q        <= cnt_clamp;
                        cur_layer_q  <= '0;
                        addr_ptr_q   <= desc_base;
                        err_q        <= 1'b0;
                        abort_pend_q <= 1'b0;
                        k_q          <= '0;
                        zero_done_q  <= (cnt_clamp == 8'd0);
                    end
                end
                StFetch: begin
                    // Read data for word k-1 arrives on cycle k.
                    if (k_q == KW'(1)) in_base_q  <= desc_rdata;
                    if (k_q == KW'(2)) out_base_q <= desc_rdata;
                    if (k_q == KW'(3)) w_base_q   <= desc_rdata;
                    if (k_q == KW'(4)) ctrl_q     <= desc_rdata;
                    k_q <= fetch_last ? '0 : k_q + KW'(1);
                end
                // Counter holds the number of cycles elapsed since conv_start.
                StLaunch: tmo_q <= TW'(1);
                StRun: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (abort) abort_pend_q <= 1'b1;
                end
                StNext: begin
                    cur_layer_q  <= cur_layer_q + 8'd1;
                    addr_ptr_q   <= addr_ptr_q + 32'(DESC_WORDS * 4);
                    abort_pend_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q != StIdle);
        desc_en    = (state_q == StFetch) && (k_q < KW'(DESC_WORDS));
        desc_addr  = desc_en ? addr_ptr_q + (32'(k_q) << 2) : 32'd0;
        conv_start = (state_q == StLaunch) && !abort;
        done       = (state_q == StFin) || zero_done_q;
    end

    assign err          = err_q;
    assign cur_layer    = cur_layer_q;
    assign cfg_in_base  = in_base_q;
    assign cfg_out_base = out_base_q;
    assign cfg_w_base   = w_base_q;
    assign cfg_ctrl     = ctrl_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: table of whole-network runs against a BRAM model and
// a delayed-finish engine model, plus hand sequences for reset behaviour.
module tb_conv_layer_sched;

    logic        clk = 1'b0;
    logic        rst, go, abort;
    logic [31:0] desc_base;
    logic [7:0]  layer_cnt;
    logic        desc_en;
    logic [31:0] desc_addr, desc_rdata;
    logic [31:0] cfg_in_base, cfg_out_base, cfg_w_base, cfg_ctrl;
    logic        conv_start, conv_finish;
    logic [7:0]  cur_layer;
    logic        busy, done, err;

    conv_layer_sched #(
        .DESC_WORDS(4),
        .MAX_LAYERS(64),
        .TIMEOUT   (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .abort       (abort),
        .desc_base   (desc_base),
        .layer_cnt   (layer_cnt),
        .desc_en     (desc_en),
        .desc_addr   (desc_addr),
        .desc_rdata  (desc_rdata),
        .cfg_in_base (cfg_in_base),
        .cfg_out_base(cfg_out_base),
        .cfg_w_base  (cfg_w_base),
        .cfg_ctrl    (cfg_ctrl),
        .conv_start  (conv_start),
        .conv_finish (conv_finish),
        .cur_layer   (cur_layer),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Descriptor contents depend only on the word index, so every layer sees distinct values.
    function automatic logic [31:0] wordf(input logic [31:0] a);
        logic [7:0] i;
        i = a[9:2];
        return {i, ~i, i ^ 8'h3C, 8'hC3};
    endfunction

    logic [31:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = wordf(32'(i) << 2);

    always @(posedge clk) if (desc_en) desc_rdata <= mem[desc_addr[9:2]];

    // Engine model: finish high exactly fin_delay cycles after the start pulse; 0 withholds it.
    int fin_delay = 0;
    int eng_cnt = 0;
    always @(posedge clk) begin
        if (rst) eng_cnt <= 0;
        else if (conv_start && fin_delay > 0) eng_cnt <= fin_delay;
        else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
    end
    assign conv_finish = (eng_cnt == 1);

    logic [31:0] run_base = 32'd0;
    int n_fetch = 0, n_start = 0, n_done = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (desc_en) begin
                chk("desc_addr", desc_addr, run_base + 32'(4 * n_fetch));
                n_fetch++;
            end
            if (conv_start) begin
                chk("cur_layer_at_start", 32'(cur_layer), 32'(n_start));
                chk("cfg_in_base",  cfg_in_base,  wordf(run_base + 32'(16 * n_start)));
                chk("cfg_out_base", cfg_out_base, wordf(run_base + 32'(16 * n_start + 4)));
                chk("cfg_w_base",   cfg_w_base,   wordf(run_base + 32'(16 * n_start + 8)));
                chk("cfg_ctrl",     cfg_ctrl,     wordf(run_base + 32'(16 * n_start + 12)));
                n_start++;
            end
            if (done) n_done++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_desc_en"}, 32'(desc_en), 32'd0);
        chk({tag, "_desc_addr"}, desc_addr, 32'd0);
        chk({tag, "_start"}, 32'(conv_start), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_cur_layer"}, 32'(cur_layer), 32'd0);
        chk({tag, "_cfg"}, cfg_in_base | cfg_out_base | cfg_w_base | cfg_ctrl, 32'd0);
    endtask

    typedef struct {
        logic [31:0] base;
        logic [7:0]  cnt;
        int          delay;
        int          abort_at;  // cycle after go to raise abort (0: never)
        int          gob_at;    // cycle after go to pulse go again (0: never)
        int          exp_starts;
        int          exp_fetches;
        int          exp_done;
        int          exp_err;
        int          exp_n;     // cycle after go at which done or err first shows
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        string s;
        s = $sformatf("v%0d", idx);
        run_base  = v.base;
        n_fetch   = 0;
        n_start   = 0;
        n_done    = 0;
        fin_delay = v.delay;
        desc_base = v.base;
        layer_cnt = v.cnt;
        go        = 1'b1;
        step();
        go = 1'b0;
        n  = 1;
        chk({s, "_err_cleared_by_go"}, 32'(err), 32'd0);
        while (!(done || err) && n < 2000) begin
            if (n == v.abort_at) abort = 1'b1;
            if (n == v.gob_at) begin
                go        = 1'b1;
                layer_cnt = 8'd5;
            end
            step();
            go = 1'b0;
            n++;
        end
        chk({s, "_end_cycle"}, 32'(n), 32'(v.exp_n));
        step();
        abort = 1'b0;
        chk({s, "_starts"}, 32'(n_start), 32'(v.exp_starts));
        chk({s, "_fetches"}, 32'(n_fetch), 32'(v.exp_fetches));
        chk({s, "_done_count"}, 32'(n_done), 32'(v.exp_done));
        chk({s, "_err_sticky"}, 32'(err), 32'(v.exp_err));
        chk({s, "_busy_after"}, 32'(busy), 32'd0);
        chk({s, "_done_low_after"}, 32'(done), 32'd0);
        step();
    endtask

    vec_t vecs [8];

    initial begin
        // Per-layer period is 4 fetch + 1 capture + 1 launch + delay + 1 next = delay + 7.
        vecs[0] = '{32'h100,      8'd1,   50, 0,  0,  1,   4,   1, 0, 58};
        vecs[1] = '{32'h200,      8'd3,   5,  0,  0,  3,   12,  1, 0, 37};
        vecs[2] = '{32'h300,      8'd0,   5,  0,  0,  0,   0,   1, 0, 1};
        vecs[3] = '{32'h140,      8'd2,   0,  0,  0,  1,   4,   0, 1, 70};
        vecs[4] = '{32'hFFFF_FFF0, 8'd2,  3,  0,  0,  2,   8,   1, 0, 21};
        vecs[5] = '{32'h240,      8'd2,   20, 10, 12, 1,   4,   0, 1, 27};
        vecs[6] = '{32'h280,      8'd1,   5,  2,  0,  0,   4,   0, 1, 6};
        vecs[7] = '{32'h0,        8'd200, 1,  0,  0,  64,  256, 1, 0, 513};

        rst = 1'b1; go = 1'b0; abort = 1'b0; desc_base = '0; layer_cnt = '0;
        repeat (3) step();
        chk_zero("reset");
        rst = 1'b0;
        step();
        chk_zero("idle");

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in the middle of FETCH returns everything to zero on the next cycle.
        run_base  = 32'h180;
        n_fetch   = 0;
        n_start   = 0;
        fin_delay = 5;
        desc_base = 32'h180;
        layer_cnt = 8'd2;
        go        = 1'b1;
        step();
        go = 1'b0;
        step();
        step();
        chk("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk_zero("rst_mid");
        rst = 1'b0;
        step();
        run_vec(vecs[0], 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
